// File: rtl/light_controller.sv
// ----------------------------------------------------------------------------
// light_controller
//
// Toggles a light on each rising edge of a push-button request. The button is
// already synchronous to clk; a press is the first sample at 1 after a sample
// at 0. Holding the button produces exactly one toggle, and releasing it never
// changes the light. No debounce or filtering is applied.
//
// Ports:
//   clk    : single clock, all state updates on the rising edge
//   reset  : synchronous, active-high; forces the light OFF and reloads the
//            button history with the current button level
//   button : press request, level-sampled every rising edge
//   light  : 1 = ON, 0 = OFF, taken straight from the state flop
// ----------------------------------------------------------------------------
module light_controller (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic light
);

    // One-bit encoding so that the state flop itself is the light output.
    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   btn_q;
    logic   press;

    // State register and button history.
    // btn_q keeps loading during reset so that a button already held high when
    // reset is released is seen as "still held", not as a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
        btn_q <= button;
    end

    // Next-state logic: rising edge of button flips the state.
    always_comb begin
        press   = button & ~btn_q;
        state_d = state_q;
        if (press) begin
            state_d = (state_q == ON) ? OFF : ON;
        end
    end

    // Output logic: the state bit drives the light directly, so there is no
    // combinational path from button to light.
    always_comb begin
        light = state_q;
    end

endmodule

// File: tb/tb_light_controller.sv
// ----------------------------------------------------------------------------
// tb_light_controller
//
// Directed bench for light_controller. Each step drives reset/button on the
// falling edge and pushes the light value expected after the next rising edge
// onto a scoreboard queue; the value is popped and compared 1 ns after that
// rising edge.
// ----------------------------------------------------------------------------
module tb_light_controller;

    logic clk;
    logic reset;
    logic button;
    logic light;

    int errors;
    int checks;

    logic  exp_q[$];
    string tag_q[$];

    light_controller dut (
        .clk    (clk),
        .reset  (reset),
        .button (button),
        .light  (light)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is a few dozen cycles long.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // Drive one cycle of stimulus and check the light after the sampling edge.
    task automatic step(input logic r, input logic b, input logic e, input string tag);
        logic  exp_v;
        string tag_v;
        @(negedge clk);
        reset  = r;
        button = b;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        tag_v = tag_q.pop_front();
        checks++;
        assert (light === exp_v) else begin
            errors++;
            $error("FAIL %s: light=%b expected %b", tag_v, light, exp_v);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        button = 1'b0;

        // Reset with button low, then idle.
        step(1'b1, 1'b0, 1'b0, "reset_state");
        step(1'b0, 1'b0, 1'b0, "idle_1");
        step(1'b0, 1'b0, 1'b0, "idle_2");

        // Two single-cycle pulses: ON then OFF.
        step(1'b0, 1'b1, 1'b1, "pulse1_on");
        step(1'b0, 1'b0, 1'b1, "pulse1_release");
        step(1'b0, 1'b1, 1'b0, "pulse2_off");
        step(1'b0, 1'b0, 1'b0, "pulse2_release");

        // Hold for five edges: a single toggle, release keeps it ON.
        step(1'b0, 1'b1, 1'b1, "hold_edge1");
        for (int i = 2; i <= 5; i++) begin
            step(1'b0, 1'b1, 1'b1, $sformatf("hold_edge%0d", i));
        end
        step(1'b0, 1'b0, 1'b1, "hold_release");
        step(1'b0, 1'b0, 1'b1, "hold_idle");

        // Reset while ON.
        step(1'b1, 1'b0, 1'b0, "reset_from_on");
        step(1'b0, 1'b0, 1'b0, "after_reset_1");
        step(1'b0, 1'b0, 1'b0, "after_reset_2");

        // Reset coincident with a press edge: no toggle, and the held button
        // must not toggle after reset is released.
        step(1'b1, 1'b1, 1'b0, "reset_with_press");
        step(1'b0, 1'b1, 1'b0, "held_after_reset_1");
        step(1'b0, 1'b1, 1'b0, "held_after_reset_2");
        step(1'b0, 1'b1, 1'b0, "held_after_reset_3");
        step(1'b0, 1'b0, 1'b0, "held_release");
        step(1'b0, 1'b1, 1'b1, "repress_on");
        step(1'b0, 1'b0, 1'b1, "repress_release");

        // Reset mid-press while ON, button kept high through deassertion.
        step(1'b0, 1'b1, 1'b0, "press_to_off");
        step(1'b0, 1'b0, 1'b0, "off_release");
        step(1'b0, 1'b1, 1'b1, "press_to_on");
        step(1'b1, 1'b1, 1'b0, "reset_mid_press");
        step(1'b0, 1'b1, 1'b0, "mid_press_held");
        step(1'b0, 1'b0, 1'b0, "mid_press_release");

        // Back-to-back pulses with one low sample between them.
        step(1'b0, 1'b1, 1'b1, "b2b_1");
        step(1'b0, 1'b0, 1'b1, "b2b_gap1");
        step(1'b0, 1'b1, 1'b0, "b2b_2");
        step(1'b0, 1'b0, 1'b0, "b2b_gap2");
        step(1'b0, 1'b1, 1'b1, "b2b_3");
        step(1'b0, 1'b0, 1'b1, "b2b_end");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
